// File: rtl/rename_freelist.sv
// rename_freelist: physical-register free list with speculative/architectural heads and one-cycle squash restore
module rename_freelist #(
  parameter int PREG_NUM = 64,
  parameter int ARCH_NUM = 32,
  parameter int RENAME_WIDTH = 4,
  parameter int COMMIT_WIDTH = 4,
  localparam int DEPTH = PREG_NUM - ARCH_NUM,
  localparam int PW = $clog2(PREG_NUM),
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [RENAME_WIDTH-1:0]      i_alloc_req,
  input  logic                         i_alloc_go,
  output logic                         o_alloc_rdy,
  output logic [RENAME_WIDTH*PW-1:0]   o_alloc_prd,
  input  logic [COMMIT_WIDTH-1:0]      i_commit_dst,
  input  logic [COMMIT_WIDTH-1:0]      i_free_vld,
  input  logic [COMMIT_WIDTH*PW-1:0]   i_free_prd,
  input  logic                         i_squash,
  output logic [CW-1:0]                o_free_count
);
  logic [PW-1:0] mem_q [DEPTH];
  logic [PW-1:0] mem_d [DEPTH];
  logic [CW-1:0] spec_head_q, spec_head_d;
  logic [CW-1:0] arch_head_q, arch_head_d;
  logic [CW-1:0] tail_q, tail_d;
  logic [CW-1:0] spec_count_q, spec_count_d;
  logic [CW-1:0] a_off, f_off, c_num;
  logic alloc;
  always_comb begin
    o_alloc_prd = '0;
    a_off = '0;
    for (int k = 0; k < RENAME_WIDTH; k++) begin
      o_alloc_prd[k*PW +: PW] = mem_q[AW'(spec_head_q + a_off)];
      a_off = a_off + CW'(i_alloc_req[k]);
    end
    o_alloc_rdy = (spec_count_q >= a_off) & ~i_squash;
    alloc = i_alloc_go & o_alloc_rdy;
    c_num = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) c_num = c_num + CW'(i_commit_dst[j]);
    mem_d = mem_q;
    f_off = '0;
    for (int j = 0; j < COMMIT_WIDTH; j++) begin
      if (i_free_vld[j]) mem_d[AW'(tail_q + f_off)] = i_free_prd[j*PW +: PW];
      f_off = f_off + CW'(i_free_vld[j]);
    end
    tail_d = tail_q + f_off;
    arch_head_d = arch_head_q + c_num;
    spec_head_d = i_squash ? arch_head_d : alloc ? spec_head_q + a_off : spec_head_q;
    spec_count_d = i_squash ? tail_d - arch_head_d : spec_count_q + f_off - (alloc ? a_off : '0);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= PW'(ARCH_NUM + i);
      spec_head_q <= '0;
      arch_head_q <= '0;
      tail_q <= CW'(DEPTH);
      spec_count_q <= CW'(DEPTH);
    end else begin
      mem_q <= mem_d;
      spec_head_q <= spec_head_d;
      arch_head_q <= arch_head_d;
      tail_q <= tail_d;
      spec_count_q <= spec_count_d;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      assert (int'(spec_count_q) + int'(f_off) <= DEPTH);
      assert (c_num <= CW'(spec_head_q - arch_head_q));
      for (int j = 0; j < COMMIT_WIDTH; j++) assert (!(i_free_vld[j] && i_free_prd[j*PW +: PW] == '0));
    end
  end
  assign o_free_count = spec_count_q;
endmodule

// File: tb/tb_rename_freelist.sv
// tb_rename_freelist: randomized and directed check of rename_freelist against a queue-based model
module tb_rename_freelist;
  logic clk = 0;
  logic rst;
  logic [3:0] i_alloc_req, i_commit_dst, i_free_vld;
  logic i_alloc_go, i_squash;
  logic [23:0] i_free_prd;
  logic o_alloc_rdy;
  logic [23:0] o_alloc_prd;
  logic [5:0] o_free_count;
  int n_cmp = 0;
  int n_bad = 0;
  int fl[$];
  int inf[$];
  int obs_prd[4];
  int obs_rdy;
  rename_freelist dut (
    .clk(clk),
    .rst(rst),
    .i_alloc_req(i_alloc_req),
    .i_alloc_go(i_alloc_go),
    .o_alloc_rdy(o_alloc_rdy),
    .o_alloc_prd(o_alloc_prd),
    .i_commit_dst(i_commit_dst),
    .i_free_vld(i_free_vld),
    .i_free_prd(i_free_prd),
    .i_squash(i_squash),
    .o_free_count(o_free_count)
  );
  always #5 clk = ~clk;
  task automatic chk(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic void model_reset();
    fl.delete();
    inf.delete();
    for (int i = 0; i < 32; i++) fl.push_back(32 + i);
  endfunction
  function automatic logic [23:0] pk(input int a, input int b, input int c, input int d);
    return {6'(d), 6'(c), 6'(b), 6'(a)};
  endfunction
  task automatic cyc(input logic r, input logic [3:0] req, input logic go, input logic [3:0] cd,
                     input logic [3:0] fv, input logic [23:0] fp, input logic sq);
    int n, c, off;
    logic rdy;
    rst = r;
    i_alloc_req = req;
    i_alloc_go = go;
    i_commit_dst = cd;
    i_free_vld = fv;
    i_free_prd = fp;
    i_squash = sq;
    @(negedge clk);
    obs_rdy = int'(o_alloc_rdy);
    for (int k = 0; k < 4; k++) obs_prd[k] = int'(o_alloc_prd[k*6 +: 6]);
    n = $countones(req);
    c = $countones(cd);
    rdy = (n <= fl.size()) && !sq;
    if (!r) begin
      chk("count", int'(o_free_count), fl.size());
      chk("rdy", obs_rdy, int'(rdy));
      off = 0;
      for (int k = 0; k < 4; k++) begin
        if (req[k]) begin
          if (off < fl.size()) chk($sformatf("prd_lane%0d", k), obs_prd[k], fl[off]);
          off++;
        end
      end
    end
    if (r) model_reset();
    else begin
      repeat (c) inf.delete(0);
      if (go && rdy) repeat (n) inf.push_back(fl.pop_front());
      for (int j = 0; j < 4; j++) if (fv[j]) fl.push_back(int'(fp[j*6 +: 6]));
      if (sq) begin
        fl = {inf, fl};
        inf.delete();
      end
    end
    @(posedge clk);
    #1;
  endtask
  initial begin
    logic r, sq, go;
    logic [3:0] req, cd, fv;
    logic [23:0] fp;
    int cnt, lim;
    model_reset();
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(1, 0, 0, 0, 0, 0, 0);
    chk("rst_count", int'(o_free_count), 32);
    cyc(0, 4'hf, 1, 0, 0, 0, 0);
    chk("t1_l0", obs_prd[0], 32);
    chk("t1_l1", obs_prd[1], 33);
    chk("t1_l2", obs_prd[2], 34);
    chk("t1_l3", obs_prd[3], 35);
    chk("t1_count", int'(o_free_count), 28);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 4'b1010, 1, 0, 0, 0, 0);
    chk("t2_l1", obs_prd[1], 32);
    chk("t2_l3", obs_prd[3], 33);
    chk("t2_count", int'(o_free_count), 30);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (7) cyc(0, 4'hf, 1, 0, 0, 0, 0);
    cyc(0, 4'b0001, 1, 0, 0, 0, 0);
    chk("t3_drained", int'(o_free_count), 3);
    cyc(0, 4'hf, 1, 4'hf, 0, 0, 0);
    chk("t3_rdy_lo", obs_rdy, 0);
    chk("t3_hold", int'(o_free_count), 3);
    cyc(0, 0, 0, 0, 4'b0001, pk(5, 0, 0, 0), 0);
    cyc(0, 4'hf, 1, 0, 0, 0, 0);
    chk("t3_rdy_hi", obs_rdy, 1);
    chk("t3_l3", obs_prd[3], 5);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 4'hf, 1, 0, 0, 0, 0);
    for (int i = 0; i < 10; i++) cyc(0, 4'hf, 1, 4'hf, 4'hf, pk(inf[0], inf[1], inf[2], inf[3]), 0);
    chk("t4_count", int'(o_free_count), 28);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 4'hf, 1, 0, 0, 0, 0);
    cyc(0, 4'hf, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'b0111, 0, 0, 0);
    cyc(0, 4'hf, 1, 0, 0, 0, 1);
    chk("t5_rdy_sq", obs_rdy, 0);
    chk("t5_count", int'(o_free_count), 29);
    cyc(0, 4'b0001, 1, 0, 0, 0, 0);
    chk("t5_l0", obs_prd[0], 35);
    cyc(1, 0, 0, 0, 0, 0, 0);
    cyc(0, 4'hf, 1, 0, 0, 0, 0);
    cyc(0, 4'hf, 1, 0, 0, 0, 0);
    cyc(0, 0, 0, 4'b0011, 4'b0101, pk(7, 0, 9, 0), 1);
    chk("t6_count", int'(o_free_count), 32);
    cyc(0, 4'hf, 1, 0, 0, 0, 0);
    chk("t6_l0", obs_prd[0], 34);
    chk("t6_l3", obs_prd[3], 37);
    cyc(1, 0, 0, 0, 0, 0, 0);
    repeat (5) cyc(0, 4'hf, 1, 0, 0, 0, 0);
    cyc(0, 4'b0011, 1, 0, 0, 0, 0);
    chk("t7_pre", int'(o_free_count), 10);
    cyc(1, 4'hf, 1, 0, 4'b0001, pk(9, 0, 0, 0), 0);
    chk("t7_count", int'(o_free_count), 32);
    cyc(0, 4'b0001, 1, 0, 0, 0, 0);
    chk("t7_l0", obs_prd[0], 32);
    for (int t = 0; t < 1500; t++) begin
      r = ($urandom_range(99) == 0);
      sq = ($urandom_range(19) == 0);
      req = 4'($urandom);
      go = ($urandom_range(3) != 0);
      cd = 0;
      cnt = 0;
      for (int j = 0; j < 4; j++) if ($urandom_range(3) != 0 && cnt < inf.size()) begin
        cd[j] = 1;
        cnt++;
      end
      lim = 32 - fl.size() - (inf.size() - cnt);
      fv = 0;
      fp = 0;
      for (int j = 0; j < 4; j++) begin
        fp[j*6 +: 6] = 6'($urandom_range(63, 1));
        if ($urandom_range(1) == 1 && lim > 0) begin
          fv[j] = 1;
          lim--;
        end
      end
      cyc(r, req, go, cd, fv, fp, sq);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
